width_conv_fifo: RTL and testbench
==================================

// Module: width_conv_fifo
// PURPOSE
//  Single-clock FIFO with bidirectional power-of-2 width conversion: packs narrow writes into wide reads
//  (up mode) or unpacks wide writes into narrow reads (down mode). Valid/ready on both sides, first-word
//  fall-through, partial-word close via wr_last_i, level/threshold flags. Sits between datapath stages
//  of differing bus widths; successor to the fixed up-sizing FIFO.
// PARAMETERS
//  WR_WIDTH      16   write data width
//  RD_WIDTH      32   read data width; max(WR,RD)/min(WR,RD) must be a power of 2 (RATIO), incl. 1
//  DEPTH_LG2     4    log2 of number of wide entries (wide = max(WR_WIDTH,RD_WIDTH))
//  LANE_LSB_FIRST 1   1: lane 0 occupies bits [N-1:0] of a wide word; 0: lane 0 occupies the MSBs
//  AFULL_THR     14   almost_full_o when level >= AFULL_THR
//  AEMPTY_THR    1    almost_empty_o when level <= AEMPTY_THR
// PORTS
//  wrclk          in   1          clock, all logic on posedge
//  rst_n          in   1          synchronous, active-low reset
//  flush_i        in   1          sync clear of pointers/level/partial state; memory untouched
//  wr_valid_i     in   1          write request
//  wr_ready_o     out  1          write accepted when valid&ready
//  wr_data_i      in   WR_WIDTH   write data
//  wr_last_i      in   1          closes the current packet (see BEHAVIOUR)
//  rd_valid_o     out  1          read data valid (FWFT)
//  rd_ready_i     in   1          read consume when valid&ready
//  rd_data_o      out  RD_WIDTH   read data
//  rd_keep_o      out  KEEP_W     valid narrow lanes of rd_data_o; KEEP_W = RD_WIDTH/min(WR,RD)
//  rd_last_o      out  1          last beat of a packet
//  level_o        out  DEPTH_LG2+1 committed wide entries
//  almost_full_o  out  1 ; almost_empty_o out 1
//  drop_cnt_o     out  8          saturating count of cycles with wr_valid_i & !wr_ready_o
// BEHAVIOUR
//  - Reset/flush: wr/rd ptrs, lane ptrs, level=0, partial state cleared; rd_valid_o=0, wr_ready_o=1,
//    rd_last_o=0, rd_keep_o=0, level_o=0, almost_empty_o=1, almost_full_o=0; drop_cnt_o=0 on reset only.
//    Reset/flush mid-packet discards the partial entry; no output glitch beyond the reset cycle.
//  - Storage: 2^DEPTH_LG2 wide entries + per-entry tag {nlanes (log2 RATIO+1 bits), last}.
//  - Up mode (WR<RD): write lane ptr wl selects lane of entry wrptr. Entry commits (level+1, wrptr+1,
//    wl=0) on the write of lane RATIO-1 or on any write with wr_last_i=1; unwritten lanes read as 0 and
//    rd_keep_o has bits [nlanes-1:0] set; rd_last_o = entry.last. One read consumes one entry.
//  - Down mode (WR>RD): each write commits one full entry (nlanes=RATIO, last=wr_last_i). Read lane ptr rl
//    selects lane; rd_keep_o=1; entry freed (level-1, rdptr+1, rl=0) on read of lane RATIO-1;
//    rd_last_o=1 only on lane RATIO-1 of an entry with last=1.
//  - RATIO=1: plain FIFO, keep=1, last passes through.
//  - Latency: commit at edge t -> rd_valid_o=1 after edge t (next cycle). No same-cycle write->read bypass.
//  - wr_ready_o = (level != 2^DEPTH_LG2) from registered level; in up mode the entry under assembly is
//    not counted, so a full FIFO stalls even the first lane. rd_valid_o = (level != 0).
//  - Simultaneous commit and free: level unchanged; ptrs each advance. At full, a read frees a slot only
//    from the next cycle (no pass-through).
//  - Pointers are DEPTH_LG2 bits, wrap modulo depth; level is the sole full/empty source.
//  - Flags almost_full_o/almost_empty_o are registered from next-level (valid same cycle as level_o).
//  - flush_i has priority over concurrent wr/rd handshakes in that cycle (both ignored).
// STRUCTURE
//  - Package width_conv_fifo_pkg: functions max_w/min_w/ratio_lg2, lane-select helper honoring
//    LANE_LSB_FIRST, entry tag typedef.
//  - Sub-module fifo_level_ctrl: ptrs, level, flags, ready/valid (commit/free strobes in).
//  - Elaboration $error if ratio not a power of 2 or thresholds exceed depth.
// TESTING
//  - Up 16->32: write 0x1111,0x2222 -> one read 0x2222_1111, keep=2'b11, last=0; level 1->0.
//  - Up partial: write 0xAAAA with wr_last_i=1 -> read 0x0000_AAAA, keep=2'b01, last=1.
//  - Down 32->8: write 0x44332211 last=1 -> reads 0x11,0x22,0x33,0x44; last only on 0x44.
//  - Fill to 16 entries: wr_ready_o=0, almost_full_o=1, held write increments drop_cnt_o; one read ->
//    wr_ready_o=1 next cycle; concurrent write+read at level 8 keeps level_o=8.
//  - Wrap: stream 100 random words each mode with random ready/valid stalls -> scoreboard exact order.
//  - flush_i mid-packet (1 of 2 lanes written) -> level_o=0, rd_valid_o=0; next packet reads clean.

Source files
------------

// File: rtl/width_conv_fifo_pkg.sv
// width_conv_fifo_pkg: shared width helpers, lane placement and per-entry tag type
package width_conv_fifo_pkg;
  localparam int NL_W = 8;
  typedef struct packed {
    logic [NL_W-1:0] nlanes;
    logic            last;
  } tag_t;
  function automatic int max_w(int a, int b);
    return a > b ? a : b;
  endfunction
  function automatic int min_w(int a, int b);
    return a < b ? a : b;
  endfunction
  function automatic int ratio_lg2(int a, int b);
    return $clog2(max_w(a, b) / min_w(a, b));
  endfunction
  // logical lane -> physical lane slot inside a wide word
  function automatic int lane_pos(int lane, int ratio, bit lsb_first);
    return lsb_first ? lane : ratio - 1 - lane;
  endfunction
endpackage

// File: rtl/width_conv_fifo_if.sv
// width_conv_fifo_if: valid/ready write and read channels of the width converting FIFO
//   write: wr_valid_i, wr_ready_o, wr_data_i[WR_WIDTH], wr_last_i
//   read : rd_valid_o, rd_ready_i, rd_data_o[RD_WIDTH], rd_keep_o[KEEP_W], rd_last_o
//   master = producer/consumer side, slave = the FIFO
interface width_conv_fifo_if import width_conv_fifo_pkg::*; #(
  parameter int WR_WIDTH = 16,
  parameter int RD_WIDTH = 32
);
  localparam int KEEP_W = RD_WIDTH / min_w(WR_WIDTH, RD_WIDTH);
  logic                wr_valid_i;
  logic                wr_ready_o;
  logic [WR_WIDTH-1:0] wr_data_i;
  logic                wr_last_i;
  logic                rd_valid_o;
  logic                rd_ready_i;
  logic [RD_WIDTH-1:0] rd_data_o;
  logic [KEEP_W-1:0]   rd_keep_o;
  logic                rd_last_o;
  modport master (
    output wr_valid_i, wr_data_i, wr_last_i, rd_ready_i,
    input  wr_ready_o, rd_valid_o, rd_data_o, rd_keep_o, rd_last_o
  );
  modport slave (
    input  wr_valid_i, wr_data_i, wr_last_i, rd_ready_i,
    output wr_ready_o, rd_valid_o, rd_data_o, rd_keep_o, rd_last_o
  );
endinterface

// File: rtl/width_conv_fifo_level_ctrl.sv
// fifo_level_ctrl: wide-entry pointers, level, threshold flags and ready/valid
//   in : wrclk, rst_n (sync, active-low), flush_i, commit_i, free_i
//   out: wrptr_o, rdptr_o, level_o, wr_ready_o, rd_valid_o, almost_full_o, almost_empty_o
module fifo_level_ctrl #(
  parameter int DEPTH_LG2  = 4,
  parameter int AFULL_THR  = 14,
  parameter int AEMPTY_THR = 1
) (
  input  logic                 wrclk,
  input  logic                 rst_n,
  input  logic                 flush_i,
  input  logic                 commit_i,
  input  logic                 free_i,
  output logic [DEPTH_LG2-1:0] wrptr_o,
  output logic [DEPTH_LG2-1:0] rdptr_o,
  output logic [DEPTH_LG2:0]   level_o,
  output logic                 wr_ready_o,
  output logic                 rd_valid_o,
  output logic                 almost_full_o,
  output logic                 almost_empty_o
);
  localparam logic [DEPTH_LG2:0] DEPTH = (DEPTH_LG2+1)'(1 << DEPTH_LG2);
  logic [DEPTH_LG2-1:0] wrptr_q, wrptr_d, rdptr_q, rdptr_d;
  logic [DEPTH_LG2:0]   level_q, level_d;
  logic                 afull_q, afull_d, aempty_q, aempty_d;
  always_comb begin
    wrptr_d  = flush_i ? '0 : wrptr_q + DEPTH_LG2'(commit_i);
    rdptr_d  = flush_i ? '0 : rdptr_q + DEPTH_LG2'(free_i);
    level_d  = flush_i ? '0 : level_q + (DEPTH_LG2+1)'(commit_i) - (DEPTH_LG2+1)'(free_i);
    afull_d  = int'(level_d) >= AFULL_THR;
    aempty_d = int'(level_d) <= AEMPTY_THR;
  end
  always_ff @(posedge wrclk) begin
    if (!rst_n) begin
      wrptr_q  <= '0;
      rdptr_q  <= '0;
      level_q  <= '0;
      afull_q  <= 1'b0;
      aempty_q <= 1'b1;
    end else begin
      wrptr_q  <= wrptr_d;
      rdptr_q  <= rdptr_d;
      level_q  <= level_d;
      afull_q  <= afull_d;
      aempty_q <= aempty_d;
    end
  end
  assign wrptr_o        = wrptr_q;
  assign rdptr_o        = rdptr_q;
  assign level_o        = level_q;
  assign wr_ready_o     = level_q != DEPTH;
  assign rd_valid_o     = level_q != '0;
  assign almost_full_o  = afull_q;
  assign almost_empty_o = aempty_q;
endmodule

// File: rtl/width_conv_fifo.sv
// width_conv_fifo: FWFT FIFO packing narrow writes into wide reads or unpacking wide writes
//   wrclk, rst_n (sync, active-low), flush_i : clock, reset, pointer/partial clear
//   bus (slave)   : write/read valid-ready channels with data, last and read keep
//   level_o, almost_full_o, almost_empty_o   : committed wide entries and threshold flags
//   drop_cnt_o    : saturating count of stalled write cycles
module width_conv_fifo import width_conv_fifo_pkg::*; #(
  parameter int WR_WIDTH       = 16,
  parameter int RD_WIDTH       = 32,
  parameter int DEPTH_LG2      = 4,
  parameter int LANE_LSB_FIRST = 1,
  parameter int AFULL_THR      = 14,
  parameter int AEMPTY_THR     = 1
) (
  input  logic                 wrclk,
  input  logic                 rst_n,
  input  logic                 flush_i,
  width_conv_fifo_if.slave     bus,
  output logic [DEPTH_LG2:0]   level_o,
  output logic                 almost_full_o,
  output logic                 almost_empty_o,
  output logic [7:0]           drop_cnt_o
);
  localparam int W      = max_w(WR_WIDTH, RD_WIDTH);
  localparam int N      = min_w(WR_WIDTH, RD_WIDTH);
  localparam int R      = W / N;
  localparam int RL     = ratio_lg2(WR_WIDTH, RD_WIDTH);
  localparam int LW     = RL > 0 ? RL : 1;
  localparam int KEEP_W = RD_WIDTH / N;
  localparam int DEPTH  = 1 << DEPTH_LG2;
  localparam bit UP     = WR_WIDTH < RD_WIDTH;
  localparam bit DN     = WR_WIDTH > RD_WIDTH;
  localparam bit LSBF   = LANE_LSB_FIRST != 0;
  localparam logic [LW-1:0] LAST_LANE = LW'(R - 1);
  localparam logic [W-1:0]  LANE_MASK = W'({N{1'b1}});
  if ((1 << RL) != R || R * N != W) begin : g_bad_ratio
    $error("width_conv_fifo: width ratio must be a power of 2");
  end
  if (AFULL_THR > DEPTH || AEMPTY_THR > DEPTH) begin : g_bad_thr
    $error("width_conv_fifo: thresholds exceed depth");
  end
  logic [W-1:0]         mem [DEPTH];
  tag_t                 tags [DEPTH];
  logic [LW-1:0]        wl_q, wl_d, rl_q, rl_d;
  logic [7:0]           drop_q, drop_d;
  logic [DEPTH_LG2-1:0] wrptr, rdptr;
  logic                 wr_fire, rd_fire, commit, free;
  logic [W-1:0]         wword, rword;
  tag_t                 wtag, rtag;
  int                   wsh, rsh;
  always_comb begin
    wr_fire = bus.wr_valid_i & bus.wr_ready_o & !flush_i;
    rd_fire = bus.rd_valid_o & bus.rd_ready_i & !flush_i;
    commit  = wr_fire & (!UP | wl_q == LAST_LANE | bus.wr_last_i);
    free    = rd_fire & (!DN | rl_q == LAST_LANE);
    wl_d    = flush_i | commit ? '0 : wl_q + LW'(wr_fire & UP);
    rl_d    = flush_i | free ? '0 : rl_q + LW'(rd_fire & DN);
    drop_d  = drop_q + 8'(bus.wr_valid_i & !bus.wr_ready_o & drop_q != 8'hff);
    wsh     = UP ? lane_pos(int'(wl_q), R, LSBF) * N : 0;
    // lane 0 of a new entry clears the rest so unwritten lanes read back as zero
    wword   = UP ? (wl_q == '0 ? '0 : mem[wrptr]) & ~(LANE_MASK << wsh) | (W'(bus.wr_data_i) << wsh)
                 : W'(bus.wr_data_i);
    wtag.nlanes = UP ? NL_W'(wl_q) + 8'd1 : NL_W'(R);
    wtag.last   = bus.wr_last_i;
    rtag    = tags[rdptr];
    rsh     = DN ? lane_pos(int'(rl_q), R, LSBF) * N : 0;
    rword   = mem[rdptr] >> rsh;
    bus.rd_data_o = bus.rd_valid_o ? RD_WIDTH'(rword) : '0;
    bus.rd_keep_o = '0;
    for (int i = 0; i < KEEP_W; i++) bus.rd_keep_o[i] = bus.rd_valid_o & (i < int'(rtag.nlanes));
    bus.rd_last_o = bus.rd_valid_o & rtag.last & (!DN | rl_q == LAST_LANE);
  end
  always_ff @(posedge wrclk) begin
    if (wr_fire) begin
      mem[wrptr] <= wword;
      if (commit) tags[wrptr] <= wtag;
    end
  end
  always_ff @(posedge wrclk) begin
    if (!rst_n) begin
      wl_q   <= '0;
      rl_q   <= '0;
      drop_q <= '0;
    end else begin
      wl_q   <= wl_d;
      rl_q   <= rl_d;
      drop_q <= drop_d;
    end
  end
  assign drop_cnt_o = drop_q;
  fifo_level_ctrl #(
    .DEPTH_LG2 (DEPTH_LG2),
    .AFULL_THR (AFULL_THR),
    .AEMPTY_THR(AEMPTY_THR)
  ) u_lvl (
    .wrclk         (wrclk),
    .rst_n         (rst_n),
    .flush_i       (flush_i),
    .commit_i      (commit),
    .free_i        (free),
    .wrptr_o       (wrptr),
    .rdptr_o       (rdptr),
    .level_o       (level_o),
    .wr_ready_o    (bus.wr_ready_o),
    .rd_valid_o    (bus.rd_valid_o),
    .almost_full_o (almost_full_o),
    .almost_empty_o(almost_empty_o)
  );
endmodule

// File: tb/tb_width_conv_fifo.sv
// tb_width_conv_fifo: directed and randomized scoreboard bench for 16->32 and 32->8 instances
module tb_width_conv_fifo;
  typedef struct packed {
    logic [31:0] d;
    logic [1:0]  k;
    logic        l;
  } exp_t;
  logic        wrclk = 1'b0;
  logic        rst_n = 1'b0;
  logic        u_flush = 1'b0, d_flush = 1'b0;
  logic [4:0]  u_level, d_level;
  logic        u_af, u_ae, d_af, d_ae;
  logic [7:0]  u_drop, d_drop;
  int          n_assert = 0, n_fail = 0;
  exp_t        uq[$], dq[$];
  logic [31:0] u_acc = '0;
  int          u_n = 0;
  always #5 wrclk = ~wrclk;
  width_conv_fifo_if #(.WR_WIDTH(16), .RD_WIDTH(32)) ui();
  width_conv_fifo_if #(.WR_WIDTH(32), .RD_WIDTH(8))  di();
  width_conv_fifo #(.WR_WIDTH(16), .RD_WIDTH(32)) u_up (
    .wrclk(wrclk), .rst_n(rst_n), .flush_i(u_flush), .bus(ui.slave), .level_o(u_level),
    .almost_full_o(u_af), .almost_empty_o(u_ae), .drop_cnt_o(u_drop)
  );
  width_conv_fifo #(.WR_WIDTH(32), .RD_WIDTH(8)) u_dn (
    .wrclk(wrclk), .rst_n(rst_n), .flush_i(d_flush), .bus(di.slave), .level_o(d_level),
    .almost_full_o(d_af), .almost_empty_o(d_ae), .drop_cnt_o(d_drop)
  );
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge wrclk);
    #1;
  endtask
  task automatic up_cycle(input logic wv, input logic [15:0] d, input logic l, input logic rr, output logic acc);
    exp_t e;
    ui.wr_valid_i = wv;
    ui.wr_data_i  = d;
    ui.wr_last_i  = l;
    ui.rd_ready_i = rr;
    acc = wv & ui.wr_ready_o;
    if (ui.rd_valid_o && rr) begin
      check("up_read_expected", 32'(uq.size() != 0), 1);
      if (uq.size() != 0) begin
        e = uq.pop_front();
        check("up_data", ui.rd_data_o, e.d);
        check("up_keep", 32'(ui.rd_keep_o), 32'(e.k));
        check("up_last", 32'(ui.rd_last_o), 32'(e.l));
      end
    end
    if (acc) begin
      u_acc |= 32'(d) << (16 * u_n);
      u_n++;
      if (u_n == 2 || l) begin
        uq.push_back('{u_acc, u_n == 2 ? 2'b11 : 2'b01, l});
        u_acc = '0;
        u_n = 0;
      end
    end
    step();
    ui.wr_valid_i = 1'b0;
    ui.rd_ready_i = 1'b0;
  endtask
  task automatic d_cycle(input logic wv, input logic [31:0] d, input logic l, input logic rr, output logic acc);
    exp_t e;
    di.wr_valid_i = wv;
    di.wr_data_i  = d;
    di.wr_last_i  = l;
    di.rd_ready_i = rr;
    acc = wv & di.wr_ready_o;
    if (di.rd_valid_o && rr) begin
      check("dn_read_expected", 32'(dq.size() != 0), 1);
      if (dq.size() != 0) begin
        e = dq.pop_front();
        check("dn_data", 32'(di.rd_data_o), e.d);
        check("dn_keep", 32'(di.rd_keep_o), 32'(e.k));
        check("dn_last", 32'(di.rd_last_o), 32'(e.l));
      end
    end
    if (acc) for (int i = 0; i < 4; i++) dq.push_back('{32'(d[8*i +: 8]), 2'b01, l && i == 3});
    step();
    di.wr_valid_i = 1'b0;
    di.rd_ready_i = 1'b0;
  endtask
  initial begin
    logic a;
    int sent;
    ui.wr_valid_i = 1'b0; ui.wr_data_i = '0; ui.wr_last_i = 1'b0; ui.rd_ready_i = 1'b0;
    di.wr_valid_i = 1'b0; di.wr_data_i = '0; di.wr_last_i = 1'b0; di.rd_ready_i = 1'b0;
    step();
    step();
    check("rst_rd_valid", 32'(ui.rd_valid_o), 0);
    check("rst_wr_ready", 32'(ui.wr_ready_o), 1);
    check("rst_level", 32'(u_level), 0);
    check("rst_aempty", 32'(u_ae), 1);
    check("rst_afull", 32'(u_af), 0);
    check("rst_keep", 32'(ui.rd_keep_o), 0);
    check("rst_last", 32'(ui.rd_last_o), 0);
    check("rst_drop", 32'(u_drop), 0);
    check("rst_dn_level", 32'(d_level), 0);
    check("rst_dn_wr_ready", 32'(di.wr_ready_o), 1);
    rst_n = 1'b1;
    step();
    up_cycle(1'b1, 16'h1111, 1'b0, 1'b0, a);
    check("up_half_level", 32'(u_level), 0);
    check("up_half_valid", 32'(ui.rd_valid_o), 0);
    up_cycle(1'b1, 16'h2222, 1'b0, 1'b0, a);
    check("up_full_level", 32'(u_level), 1);
    up_cycle(1'b0, 16'h0, 1'b0, 1'b1, a);
    check("up_read_level", 32'(u_level), 0);
    up_cycle(1'b1, 16'hAAAA, 1'b1, 1'b0, a);
    check("up_part_level", 32'(u_level), 1);
    check("up_part_aempty", 32'(u_ae), 1);
    up_cycle(1'b0, 16'h0, 1'b0, 1'b1, a);
    check("up_part_drained", 32'(u_level), 0);
    for (int i = 0; i < 16; i++) up_cycle(1'b1, 16'(i), 1'b1, 1'b0, a);
    check("fill_level", 32'(u_level), 16);
    check("fill_wr_ready", 32'(ui.wr_ready_o), 0);
    check("fill_afull", 32'(u_af), 1);
    check("fill_aempty", 32'(u_ae), 0);
    up_cycle(1'b1, 16'hBEEF, 1'b1, 1'b0, a);
    up_cycle(1'b1, 16'hBEEF, 1'b1, 1'b0, a);
    check("fill_drop2", 32'(u_drop), 2);
    check("fill_held_level", 32'(u_level), 16);
    up_cycle(1'b1, 16'hCAFE, 1'b1, 1'b1, a);
    check("full_read_level", 32'(u_level), 15);
    check("full_read_ready", 32'(ui.wr_ready_o), 1);
    check("full_read_drop3", 32'(u_drop), 3);
    check("full_read_afull", 32'(u_af), 1);
    for (int i = 0; i < 7; i++) up_cycle(1'b0, 16'h0, 1'b0, 1'b1, a);
    check("mid_level", 32'(u_level), 8);
    check("mid_afull", 32'(u_af), 0);
    up_cycle(1'b1, 16'h5555, 1'b1, 1'b1, a);
    check("concurrent_level", 32'(u_level), 8);
    for (int i = 0; i < 8; i++) up_cycle(1'b0, 16'h0, 1'b0, 1'b1, a);
    check("drain_level", 32'(u_level), 0);
    check("drain_aempty", 32'(u_ae), 1);
    check("drain_valid", 32'(ui.rd_valid_o), 0);
    up_cycle(1'b1, 16'h7777, 1'b0, 1'b0, a);
    u_flush = 1'b1;
    ui.wr_valid_i = 1'b1; ui.wr_data_i = 16'h9999; ui.wr_last_i = 1'b1;
    step();
    u_flush = 1'b0;
    ui.wr_valid_i = 1'b0;
    u_acc = '0; u_n = 0; uq.delete();
    check("flush_level", 32'(u_level), 0);
    check("flush_valid", 32'(ui.rd_valid_o), 0);
    up_cycle(1'b1, 16'h1234, 1'b0, 1'b0, a);
    up_cycle(1'b1, 16'h5678, 1'b1, 1'b0, a);
    check("post_flush_level", 32'(u_level), 1);
    up_cycle(1'b0, 16'h0, 1'b0, 1'b1, a);
    d_cycle(1'b1, 32'h44332211, 1'b1, 1'b0, a);
    check("dn_level_w", 32'(d_level), 1);
    for (int i = 0; i < 3; i++) d_cycle(1'b0, 32'h0, 1'b0, 1'b1, a);
    check("dn_level_3rd", 32'(d_level), 1);
    d_cycle(1'b0, 32'h0, 1'b0, 1'b1, a);
    check("dn_level_done", 32'(d_level), 0);
    sent = 0;
    for (int c = 0; c < 4000 && (sent < 100 || uq.size() != 0); c++) begin
      up_cycle(sent < 100 && $urandom_range(3) != 0, 16'($urandom), sent == 99 || $urandom_range(4) == 0,
               $urandom_range(2) != 0, a);
      if (a) sent++;
    end
    check("up_stream_sent", sent, 100);
    check("up_stream_drained", 32'(uq.size()), 0);
    check("up_stream_level", 32'(u_level), 0);
    sent = 0;
    for (int c = 0; c < 4000 && (sent < 100 || dq.size() != 0); c++) begin
      d_cycle(sent < 100 && $urandom_range(3) != 0, $urandom, $urandom_range(4) == 0,
              $urandom_range(2) != 0, a);
      if (a) sent++;
    end
    check("dn_stream_sent", sent, 100);
    check("dn_stream_drained", 32'(dq.size()), 0);
    check("dn_stream_level", 32'(d_level), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
